// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags: write side, read side, flags and error pulses.
interface sync_fifo_flags_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             w_en;
  logic [WIDTH-1:0] w_data;
  logic             full;
  logic             almost_full;
  logic             r_en;
  logic [WIDTH-1:0] r_data;
  logic             empty;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w_en, w_data, r_en,
    input  full, almost_full, r_data, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en,
    output full, almost_full, r_data, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with full/empty, programmable almost flags, occupancy and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_fifo_flags_if.slave     bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH > DEPTH - 1) begin : g_param_check
    $error("sync_fifo_flags: illegal parameter set");
  end

  logic [CW-1:0]    w_ptr;
  logic [CW-1:0]    r_ptr;
  logic [CW-1:0]    occ;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty_i;
  logic             full_i;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_q;
  logic             udf_q;

  // Flags decode from registered pointers only.
  assign empty_i = (w_ptr == r_ptr);
  assign full_i  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
  assign occ     = w_ptr - r_ptr;

  assign wr_acc  = bus.w_en && !full_i;
  assign rd_acc  = bus.r_en && !empty_i;

  assign bus.empty        = empty_i;
  assign bus.full         = full_i;
  assign bus.count        = occ;
  assign bus.almost_full  = (occ >= CW'(AFULL_TH));
  assign bus.almost_empty = (occ <= CW'(AEMPTY_TH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + CW'(1);
      if (rd_acc) r_ptr <= r_ptr + CW'(1);
      ovf_q <= bus.w_en && full_i;
      udf_q <= bus.r_en && empty_i;
    end
  end

  // Storage is not reset; pointer reset discards its contents logically.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr[AW-1:0]] <= bus.w_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.r_data = mem[r_ptr[AW-1:0]];
`else
  logic [WIDTH-1:0] r_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_data_q <= '0;
    else if (rd_acc) r_data_q <= mem[r_ptr[AW-1:0]];
  end

  assign bus.r_data = r_data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: driver models occupancy and pushes written words, monitor pops on reads.
module tb_sync_fifo_flags;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;
  localparam int unsigned AE    = 4;

  logic clk;
  logic rst;

  sync_fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_flags #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_count = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             pend;
  logic [WIDTH-1:0] pend_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares read data against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
`ifdef SYNC_FIFO_FWFT_EN
      if (bus.r_en && !bus.empty) begin
        if (exp_q.size() == 0) chk("sb_underrun", 32'd0, 32'd1);
        else chk("fwft_rdata", 32'(bus.r_data), 32'(exp_q.pop_front()));
      end
`else
      if (pend) begin
        chk("rdata", 32'(bus.r_data), 32'(pend_val));
        pend = 1'b0;
      end
      if (bus.r_en && !bus.empty) begin
        if (exp_q.size() == 0) chk("sb_underrun", 32'd0, 32'd1);
        else begin
          pend_val = exp_q.pop_front();
          pend     = 1'b1;
        end
      end
`endif
    end
  end

  task automatic chk_flags();
    chk("count",        32'(bus.count),        32'(m_count));
    chk("empty",        32'(bus.empty),        32'(m_count == 0));
    chk("full",         32'(bus.full),         32'(m_count == int'(DEPTH)));
    chk("almost_full",  32'(bus.almost_full),  32'(m_count >= int'(AF)));
    chk("almost_empty", 32'(bus.almost_empty), 32'(m_count <= int'(AE)));
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re);
    bit wacc, racc, e_ovf, e_udf;
    wacc  = we && (m_count < int'(DEPTH));
    racc  = re && (m_count > 0);
    e_ovf = we && (m_count == int'(DEPTH));
    e_udf = re && (m_count == 0);
    bus.w_en   = we;
    bus.w_data = wd;
    bus.r_en   = re;
    if (wacc) exp_q.push_back(wd);
    m_count = m_count + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk_flags();
    chk("overflow",  32'(bus.overflow),  32'(e_ovf));
    chk("underflow", 32'(bus.underflow), 32'(e_udf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pend       = 1'b0;
    pend_val   = '0;
    rst        = 1'b1;
    bus.w_en   = 1'b0;
    bus.r_en   = 1'b0;
    bus.w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_flags();
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rdata", 32'(bus.r_data), 32'd0);
`endif
    rst = 1'b0;

    // Fill 0x00..0x0F; almost_full at 12, full at 16.
    for (int i = 0; i < 16; i++) step(1'b1, WIDTH'(i), 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);

    // Overflow attempt, then drain in order.
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Underflow from empty; read data holds.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rdata_hold", 32'(bus.r_data), 32'h0F);
`endif

    // Fill to 8, then 40 cycles of simultaneous read/write across the pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(8'h10 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Simultaneous request at empty: only the write is taken.
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Asynchronous reset mid-stream at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'hC0 + i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    m_count = 0;
    exp_q.delete();
    chk_flags();
`ifndef SYNC_FIFO_FWFT_EN
    chk("midrst_rdata", 32'(bus.r_data), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: word shows without r_en, r_en pops it.
    step(1'b1, 8'h5A, 1'b0);
    chk("fwft_show", 32'(bus.r_data), 32'h5A);
    step(1'b0, 8'h00, 1'b0);
    chk("fwft_hold", 32'(bus.r_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("sb_no_pending", 32'(pend), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
